// File: rtl/fetch_sequencer_pkg.sv
// ---------------------------------------------------------------
// fetch_sequencer_pkg -- fetch FSM state encoding and PC step.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] C_PC_INC = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] i_addr);
    return {i_addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// ---------------------------------------------------------------
// fetch_sequencer_if -- redirect, hazard, imem and delivery bus.
// Rev 1.0 (FETCH_MISALIGN_TRAP_EN adds misalign)
// ---------------------------------------------------------------
`default_nettype none

interface fetch_sequencer_if;

  logic        branch;
  logic [31:0] branch_addr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        flush;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;

  modport master (
    input  branch, branch_addr, stall, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instr, instr_pc, instr_valid, flush, misalign
  );

  modport slave (
    output branch, branch_addr, stall, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, flush, misalign
  );
`else
  modport master (
    input  branch, branch_addr, stall, imem_ready, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instr, instr_pc, instr_valid, flush
  );

  modport slave (
    output branch, branch_addr, stall, imem_ready, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, flush
  );
`endif

endinterface

`default_nettype wire

// File: rtl/fetch_sequencer_buffer.sv
// ---------------------------------------------------------------
// fetch_buffer -- one-entry instruction/PC holding register.
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module fetch_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------
// fetch_sequencer -- instruction fetch FSM with redirect and stall hold.
// Rev 1.0 (optional FETCH_MISALIGN_TRAP_EN: trap misaligned branches)
// ---------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;

  logic        r_run;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_req_pc;
  logic        r_kill;
  logic        w_kill_nxt;
  logic        r_valid;
  logic        w_valid_nxt;
  logic [31:0] r_instr;
  logic [31:0] w_instr_nxt;
  logic [31:0] r_instr_pc;
  logic [31:0] w_instr_pc_nxt;
  logic        r_flush;
  logic        w_accept;
  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_buf_load;
  logic        w_buf_clear;
  logic [31:0] w_buf_instr;
  logic [31:0] w_buf_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_misalign;

  assign w_misalign = bus.branch && (bus.branch_addr[1:0] != 2'b00);
  assign w_redirect = bus.branch && !w_misalign;
  assign w_target   = bus.branch_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_misalign;
  end

  assign bus.misalign = r_misalign;
`else
  logic w_unused_lsbs;

  assign w_redirect    = bus.branch;
  assign w_target      = align_word(bus.branch_addr);
  assign w_unused_lsbs = ^bus.branch_addr[1:0];
`endif

  // r_run keeps imem_req low until the first edge after reset release
  assign bus.imem_req  = r_run && (r_state == ST_REQ);
  assign bus.imem_addr = r_pc;
  assign w_accept      = bus.imem_req && bus.imem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_REQ;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_kill_nxt     = r_kill;
    w_valid_nxt    = 1'b0;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_buf_load     = 1'b0;
    w_buf_clear    = 1'b0;

    case (r_state)
      ST_REQ: begin
        if (w_accept) begin
          w_pc_nxt    = r_pc + C_PC_INC;
          w_kill_nxt  = 1'b0;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.imem_rvalid) begin
          w_state_nxt = ST_REQ;
          w_kill_nxt  = 1'b0;
          if (!r_kill && !w_redirect) begin
            if (bus.stall) begin
              w_buf_load  = 1'b1;
              w_state_nxt = ST_HOLD;
            end else begin
              w_valid_nxt    = 1'b1;
              w_instr_nxt    = bus.imem_rdata;
              w_instr_pc_nxt = r_req_pc;
            end
          end
        end
      end
      ST_HOLD: begin
        if (!bus.stall) begin
          w_valid_nxt    = 1'b1;
          w_instr_nxt    = w_buf_instr;
          w_instr_pc_nxt = w_buf_pc;
          w_buf_clear    = 1'b1;
          w_state_nxt    = ST_REQ;
        end
      end
      default: w_state_nxt = ST_REQ;
    endcase

    // A redirect overrides every delivery decision made above
    if (w_redirect) begin
      w_pc_nxt       = w_target;
      w_valid_nxt    = 1'b0;
      w_instr_nxt    = r_instr;
      w_instr_pc_nxt = r_instr_pc;
      w_buf_load     = 1'b0;
      w_buf_clear    = 1'b1;
      case (r_state)
        ST_REQ: begin
          w_kill_nxt  = w_accept;
          w_state_nxt = w_accept ? ST_RESP : ST_REQ;
        end
        ST_RESP: begin
          w_kill_nxt  = !bus.imem_rvalid;
          w_state_nxt = bus.imem_rvalid ? ST_REQ : ST_RESP;
        end
        default: begin
          w_kill_nxt  = 1'b0;
          w_state_nxt = ST_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run      <= 1'b0;
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_kill     <= 1'b0;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_flush    <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_pc       <= w_pc_nxt;
      r_kill     <= w_kill_nxt;
      r_valid    <= w_valid_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_flush    <= w_redirect;
      if (w_accept) r_req_pc <= r_pc;
    end
  end

  fetch_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_instr (bus.imem_rdata),
    .i_pc    (r_req_pc),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.flush       = r_flush;

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 branch  input  1  redirect request from branch controller; one-cycle pulse.
REQ-005 branch_addr  input  32  redirect target; sampled only when branch=1.
REQ-006 stall  input  1  hazard-unit hold; freezes instruction delivery.
REQ-007 imem_req  output  1  instruction memory request valid.
REQ-008 imem_addr  output  32  request address; stable while imem_req=1 and imem_ready=0.
REQ-009 imem_ready  input  1  memory accepts request when imem_req=1 and imem_ready=1.
REQ-010 imem_rvalid  input  1  read data valid; at most one response per accepted request, in order.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 instr  output  32  delivered instruction.
REQ-013 instr_pc  output  32  address of delivered instruction.
REQ-014 instr_valid  output  1  instr/instr_pc valid.
REQ-015 flush  output  1  one-cycle pulse killing the younger IF/ID contents.

Function
REQ-016 States SHALL be REQ (drive request), RESP (await imem_rvalid), HOLD (buffered instruction, stall=1).
REQ-017 REQ: imem_req=1, imem_addr=pc; on accept, pc<=pc+4 (modulo 2^32, wraps FFFF_FFFC->0000_0000) and go to RESP.
REQ-018 RESP: on imem_rvalid with stall=0, drive instr/instr_pc/instr_valid=1 for one cycle and go to REQ.
REQ-019 RESP: on imem_rvalid with stall=1, latch word into a one-entry buffer and go to HOLD; instr_valid=0.
REQ-020 HOLD: when stall falls, present buffered word with instr_valid=1 for one cycle, then go to REQ.
REQ-021 Minimum latency SHALL be 2 cycles from request accept to instr_valid with zero-wait memory.
REQ-022 branch=1 SHALL load pc<=branch_addr, assert flush next cycle, discard any buffered word, and return to REQ.
REQ-023 branch during RESP SHALL set a kill flag; the pending response SHALL be consumed and dropped (instr_valid=0), then go to REQ.
REQ-024 branch coinciding with request accept SHALL win: pc<=branch_addr, the accepted request treated as killed per REQ-023.
REQ-025 branch coinciding with imem_rvalid SHALL drop that response; instr_valid stays 0.
REQ-026 branch has priority over stall; stall SHALL NOT block a redirect.
REQ-027 stall=1 in REQ SHALL NOT suppress requests; only delivery is held.

Reset
REQ-028 On rst: pc=RESET_PC, state=REQ, imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, flush=0, kill flag and buffer cleared.
REQ-029 imem_req SHALL first assert on the first clk edge after rst deasserts.
REQ-030 Reset mid-RESP SHALL abandon the outstanding request; a later stray imem_rvalid SHALL be ignored until a new request is accepted.

Configuration
REQ-031 Macro FETCH_MISALIGN_TRAP_EN defined: adds output misalign (1 bit); branch with branch_addr[1:0]!=0 SHALL pulse misalign, leave pc unchanged, and issue no flush.
REQ-032 Macro undefined: no misalign port; branch_addr[1:0] forced to 0 on redirect.

Structure
REQ-033 Shared package SHALL hold state encoding typedef (REQ, RESP, HOLD) and the PC increment constant 4.
REQ-034 One sub-module fetch_buffer (one-entry instruction/PC holding register with load/clear) is natural; everything else inline.

Verification
REQ-035 Reset, RESET_PC=0, zero-wait memory -> imem_addr 0,4,8; instr_valid at cycles 2,4,6 with instr_pc 0,4,8.
REQ-036 stall=1 for 3 cycles while word at 0x8 returns -> instr_valid=0 during stall, then one pulse with instr_pc=0x8.
REQ-037 branch=1, branch_addr=0x100 while response for 0xC pending -> 0xC response dropped, flush pulse, next imem_addr=0x100.
REQ-038 pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000.
REQ-039 rst asserted in RESP, late imem_rvalid after deassert -> ignored; fetch restarts at RESET_PC.
REQ-040 With FETCH_MISALIGN_TRAP_EN, branch_addr=0x102 -> misalign pulse, no flush, fetch continues sequentially.
